// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampling, 8N1) feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames instead.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   i_hclk,
  input  logic                   i_hreset,
  input  logic                   i_en,
  input  logic [15:0]            i_prescale,
  input  logic                   i_rx,
  input  logic                   i_rd,
  output logic [7:0]             o_rdata,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_fe,
  output logic                   o_ovr,
  input  logic                   i_clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic [15:0]   r_tick_cnt;
  logic [2:0]    r_state, w_state_d;
  logic [3:0]    r_os_cnt, w_os_cnt_d;
  logic [2:0]    r_bit_cnt, w_bit_cnt_d;
  logic [7:0]    r_shift, w_shift_d;
  logic          w_fall, w_tick, w_start_det, w_push, w_fe_set;
  logic          w_pop, w_wr, w_ovr_set;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level, w_level_d;
  logic          r_fe, r_ovr;
  logic [7:0]    r_mem [DEPTH];

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall      = r_rx_prev & ~r_rx_sync;
  assign w_start_det = i_en && (r_state == ST_IDLE) && w_fall;
  assign w_tick      = i_en && (r_tick_cnt == 16'd0);

  // Down-counter reloads from i_prescale, so a new prescale applies at the next reload.
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_tick_cnt <= 16'd0;
    end else if (!i_en) begin
      r_tick_cnt <= 16'd0;
    end else if (w_start_det || (r_tick_cnt == 16'd0)) begin
      r_tick_cnt <= i_prescale;
    end else begin
      r_tick_cnt <= r_tick_cnt - 16'd1;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_os_cnt_d  = r_os_cnt;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_push      = 1'b0;
    w_fe_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_d  = ST_START;
          w_os_cnt_d = 4'd0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_os_cnt == 4'd7) begin
            w_os_cnt_d  = 4'd0;
            w_bit_cnt_d = 3'd0;
            w_state_d   = r_rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            w_os_cnt_d = r_os_cnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_os_cnt_d = r_os_cnt + 4'd1;
          if (r_os_cnt == 4'd15) begin
            w_shift_d = {r_rx_sync, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_d = ST_PARITY;
`else
              w_state_d = ST_STOP;
`endif
            end else begin
              w_bit_cnt_d = r_bit_cnt + 3'd1;
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_os_cnt_d = r_os_cnt + 4'd1;
          if (r_os_cnt == 4'd15) begin
            // Even parity: the received bit must equal the XOR of the data bits.
            if (r_rx_sync != ^r_shift) begin
              w_fe_set  = 1'b1;
              w_state_d = ST_IDLE;
            end else begin
              w_state_d = ST_STOP;
            end
          end
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_os_cnt_d = r_os_cnt + 4'd1;
          if (r_os_cnt == 4'd15) begin
            w_state_d = ST_IDLE;
            w_push    = r_rx_sync;
            w_fe_set  = ~r_rx_sync;
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
    if (!i_en) begin
      w_state_d   = ST_IDLE;
      w_os_cnt_d  = 4'd0;
      w_bit_cnt_d = 3'd0;
      w_push      = 1'b0;
      w_fe_set    = 1'b0;
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state   <= ST_IDLE;
      r_os_cnt  <= 4'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_state   <= w_state_d;
      r_os_cnt  <= w_os_cnt_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
    end
  end

  // A pop frees the slot in the same cycle, so a push into a full FIFO with RD high is kept.
  assign w_pop     = i_rd && !o_empty;
  assign w_wr      = w_push && (!o_full || w_pop);
  assign w_ovr_set = w_push && o_full && !w_pop;

  always_comb begin
    w_level_d = r_level;
    case ({w_wr, w_pop})
      2'b10:   w_level_d = r_level + LW'(1);
      2'b01:   w_level_d = r_level - LW'(1);
      default: w_level_d = r_level;
    endcase
  end

  always_ff @(posedge i_hclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_shift_d;
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_fe     <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_d;
      if (i_clr_err) begin
        r_fe  <= 1'b0;
        r_ovr <= 1'b0;
      end else begin
        r_fe  <= r_fe | w_fe_set;
        r_ovr <= r_ovr | w_ovr_set;
      end
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_fe    = r_fe;
  assign o_ovr   = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: PRESCALE=0 so one bit is 16 clocks (160 ns at 100 MHz).
module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Negedge index within a frame on which the stop-bit push first becomes visible.
  localparam int PUSH_C = (NB - 1) * 16 + 11;

  logic        clk = 1'b0;
  logic        hreset;
  logic        en;
  logic [15:0] prescale;
  logic        rx;
  logic        rd;
  logic [7:0]  rdata;
  logic        empty;
  logic        full;
  logic [4:0]  level;
  logic        fe;
  logic        ovr;
  logic        clr_err;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .i_hclk     (clk),
    .i_hreset   (hreset),
    .i_en       (en),
    .i_prescale (prescale),
    .i_rx       (rx),
    .i_rd       (rd),
    .o_rdata    (rdata),
    .o_empty    (empty),
    .o_full     (full),
    .o_level    (level),
    .o_fe       (fe),
    .o_ovr      (ovr),
    .i_clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one frame; optionally checks LEVEL around the push and/or pops at the push cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v,
                            input logic pop_at_push, input int lvl_pre, input int lvl_post);
    logic [9:0] fr;
    fr = {par_v, d, 1'b0};
    for (int c = 0; c < NB * 16; c++) begin
      @(negedge clk);
      if (c == PUSH_C - 1) begin
        if (lvl_pre >= 0) check_eq("level_before_push", 32'(level), 32'(lvl_pre));
        if (pop_at_push) rd = 1'b1;
      end
      if (c == PUSH_C) begin
        if (lvl_post >= 0) check_eq("level_after_push", 32'(level), 32'(lvl_post));
        rd = 1'b0;
      end
      rx = ((c / 16) == NB - 1) ? stop_v : fr[c / 16];
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    hreset   = 1'b1;
    en       = 1'b0;
    prescale = 16'd0;
    rx       = 1'b1;
    rd       = 1'b0;
    clr_err  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_fe", 32'(fe), 32'd0);
    check_eq("rst_ovr", 32'(ovr), 32'd0);
    hreset = 1'b0;
    en     = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte with push-timing check.
    send_frame(8'h48, 1'b1, ^8'h48, 1'b0, 0, 1);
    check_eq("b48_rdata", 32'(rdata), 32'h48);
    check_eq("b48_level", 32'(level), 32'd1);
    check_eq("b48_fe", 32'(fe), 32'd0);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check_eq("pop_empty", 32'(empty), 32'd1);

    // Overfill: the 17th byte is dropped and flags overrun.
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, ^8'(i), 1'b0, -1, -1);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_ovr", 32'(ovr), 32'd1);
    check_eq("fill_level", 32'(level), 32'd16);
    check_eq("fill_head", 32'(rdata), 32'h00);
    pulse_clr();
    check_eq("clr_ovr", 32'(ovr), 32'd0);

    // Push while full with a same-cycle pop is accepted without overrun.
    send_frame(8'h77, 1'b1, ^8'h77, 1'b1, 16, 16);
    check_eq("fullpop_level", 32'(level), 32'd16);
    check_eq("fullpop_ovr", 32'(ovr), 32'd0);
    for (int i = 1; i < 17; i++) begin
      check_eq("drain_data", 32'(rdata), (i == 16) ? 32'h77 : 32'(i));
      rd = 1'b1;
      @(negedge clk);
    end
    rd = 1'b0;
    check_eq("drain_empty", 32'(empty), 32'd1);
    rd = 1'b1;
    repeat (2) @(negedge clk);
    rd = 1'b0;
    check_eq("rd_empty_nowrap", 32'(level), 32'd0);

    // Framing error: stop bit held low.
    send_frame(8'h55, 1'b0, ^8'h55, 1'b0, -1, -1);
    check_eq("fe_set", 32'(fe), 32'd1);
    check_eq("fe_level", 32'(level), 32'd0);
    pulse_clr();
    check_eq("fe_clr", 32'(fe), 32'd0);

    // Short glitch on the idle line.
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_level", 32'(level), 32'd0);
    check_eq("glitch_fe", 32'(fe), 32'd0);

    // Reset during data bit 4 of 0xA5, then a clean 0x3C.
    a5 = 8'hA5;
    for (int c = 0; c < 88; c++) begin
      @(negedge clk);
      rx = (c < 16) ? 1'b0 : a5[(c - 16) / 16];
    end
    @(negedge clk);
    hreset = 1'b1;
    rx     = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_level", 32'(level), 32'd0);
    check_eq("midrst_empty", 32'(empty), 32'd1);
    hreset = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, 0, 1);
    check_eq("after_rst_rdata", 32'(rdata), 32'h3C);
    check_eq("after_rst_level", 32'(level), 32'd1);
    check_eq("after_rst_fe", 32'(fe), 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1, -1);
    check_eq("par_bad_fe", 32'(fe), 32'd1);
    check_eq("par_bad_level", 32'(level), 32'd1);
    pulse_clr();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0, 1);
    check_eq("par_ok_rdata", 32'(rdata), 32'h07);
    check_eq("par_ok_fe", 32'(fe), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning receive FIFO entries; it SHALL be a power of two and at least 2.
REQ-002 HCLK  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 HRESET  input  1  asynchronous, active-high reset.
REQ-004 EN  input  1  receiver enable; when low the FSM SHALL be held in IDLE and the tick counter cleared, while the FIFO contents are kept.
REQ-005 PRESCALE  input  16  HCLK cycles per 16x-oversample tick, minus one.
REQ-006 RX  input  1  asynchronous serial line from the SoC UART TX pin; idle level is high.
REQ-007 RD  input  1  pop strobe, one entry per cycle while high.
REQ-008 RDATA  output  8  FIFO head entry, first-word fall-through; this value is don't-care when EMPTY is high.
REQ-009 EMPTY  output  1  FIFO holds zero entries.
REQ-010 FULL  output  1  FIFO holds DEPTH entries.
REQ-011 LEVEL  output  log2(DEPTH)+1  current entry count.
REQ-012 FE  output  1  sticky framing-error flag.
REQ-013 OVR  output  1  sticky overrun flag.
REQ-014 CLR_ERR  input  1  clears FE and OVR.

Function
REQ-015 RX SHALL pass through a two-flop synchronizer whose flops reset to 1; all sampling SHALL use the synchronized value.
REQ-016 A tick SHALL be generated every PRESCALE+1 HCLK cycles; with PRESCALE=0 a tick occurs every cycle, so one bit is 16 cycles.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY (macro only) and STOP; the reset state is IDLE.
REQ-018 In IDLE, a synchronized 1->0 transition SHALL move the FSM to START and restart the tick counter.
REQ-019 START SHALL sample RX after 8 ticks; a 0 moves the FSM to DATA, and a 1 is treated as a glitch and returns it to IDLE with no flag set.
REQ-020 DATA SHALL sample one bit every 16 ticks, 8 bits, LSB first, and then advance.
REQ-021 STOP SHALL sample RX after 16 ticks.
REQ-022 If the stop sample is 1, the byte SHALL be pushed into the FIFO, and it SHALL be visible on RDATA/LEVEL on the cycle after the sample.
REQ-023 If the stop sample is 0, the byte SHALL be discarded and FE set, and the FSM SHALL return to IDLE, where a new start is recognized only after a fresh 1->0 transition.
REQ-024 A push while FULL with RD low SHALL be dropped and SHALL set OVR.
REQ-025 A push while FULL with RD high SHALL be accepted, LEVEL stays at DEPTH, and OVR is not set.
REQ-026 RD while EMPTY SHALL be ignored, and LEVEL SHALL not wrap.
REQ-027 A simultaneous push and pop in any non-full, non-empty state SHALL leave LEVEL unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 CLR_ERR SHALL take priority over a same-cycle error set, so the flag reads 0 on the next cycle.
REQ-030 PRESCALE changes SHALL take effect at the next tick-counter reload.

Reset
REQ-031 While HRESET is high: FSM=IDLE, pointers=0, LEVEL=0, EMPTY=1, FULL=0, FE=0, OVR=0, synchronizer=1, tick and bit counters=0.
REQ-032 A reset asserted mid-frame SHALL abandon the frame and push nothing.
REQ-033 After release, reception SHALL begin at the next falling edge on RX.

Configuration
REQ-034 With UART_RX_PARITY_EN defined, frames SHALL be 8E1: PARITY samples one bit 16 ticks after the last data bit, and on mismatch the byte is discarded and FE set.
REQ-035 Without UART_RX_PARITY_EN, frames SHALL be 8N1, the PARITY state SHALL not exist, and DATA goes directly to STOP.

Verification
REQ-036 PRESCALE=0, RX sends 0x48 at 160 ns/bit -> RDATA=0x48, LEVEL=1, FE=0, with the push 16 ticks after the last data-bit sample.
REQ-037 Send 17 bytes 0x00..0x10 with DEPTH=16 and no RD -> FULL=1, OVR=1; popping 16 times yields 0x00..0x0F and then EMPTY=1.
REQ-038 Hold RX low through the stop bit of 0x55 -> FE=1, LEVEL unchanged; CLR_ERR pulse -> FE=0.
REQ-039 A 3-cycle low glitch on idle RX -> no push, FE=0, FSM back in IDLE.
REQ-040 HRESET asserted during data bit 4 of 0xA5 -> LEVEL=0, EMPTY=1; a following 0x3C is received correctly.
REQ-041 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> FE=1 and no push; with parity bit 1 -> RDATA=0x07.
